// File: rtl/io_bus_pkg.sv
// Shared types and constants for the memory-mapped I/O bus controller.
// Holds the controller state encoding, the error read value and the wait-counter sizing helper.
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam int ERR_RDATA = 0;

    // Counter must be able to hold values up to TIMEOUT.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/io_bus_decode.sv
// Combinational region decoder: region field value f maps to device f-1 when 1 <= f <= N_DEV.
// Field value 0 and values above N_DEV are unmapped.
module io_bus_decode
    import io_bus_pkg::*;
#(
    parameter int SEL_HI = 31,
    parameter int SEL_LO = 20,
    parameter int N_DEV  = 8,
    parameter int IDX_W  = (N_DEV > 1) ? $clog2(N_DEV) : 1
) (
    input  logic [SEL_HI-SEL_LO:0] i_field,
    output logic                   o_hit,
    output logic [IDX_W-1:0]       o_index,
    output logic [N_DEV-1:0]       o_onehot
);

    always_comb begin
        o_hit    = 1'b0;
        o_index  = '0;
        o_onehot = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (int'(i_field) == i + 1) begin
                o_hit       = 1'b1;
                o_index     = IDX_W'(i);
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O bus controller: decodes the CPU address, handshakes with a variable-latency
// device and completes every access with an ack, flagging unmapped or timed-out accesses as errors.
module io_bus_ctrl
    import io_bus_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int SEL_HI  = 31,
    parameter int SEL_LO  = 20,
    parameter int N_DEV   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [DATA_W-1:0]       cpu_wdata,
    output logic                    cpu_ack,
    output logic                    cpu_err,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic [N_DEV-1:0]        dev_sel,
    output logic                    dev_we,
    output logic [ADDR_W-1:0]       dev_addr,
    output logic [DATA_W-1:0]       dev_wdata,
    input  logic [N_DEV*DATA_W-1:0] dev_rdata,
    input  logic [N_DEV-1:0]        dev_ack,
    output logic [7:0]              err_count
);

    localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam int CNT_W = cnt_width(TIMEOUT);

    logic              w_hit;
    logic [IDX_W-1:0]  w_idx;
    logic [N_DEV-1:0]  w_onehot;
    logic              w_dev_ack;
    logic [DATA_W-1:0] w_dev_rdata;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [N_DEV-1:0]  r_dev_sel;
    logic              r_dev_we;
    logic [ADDR_W-1:0] r_dev_addr;
    logic [DATA_W-1:0] r_dev_wdata;
    logic              r_cpu_ack;
    logic              r_cpu_err;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [7:0]        r_err_count;

    io_bus_decode #(
        .SEL_HI (SEL_HI),
        .SEL_LO (SEL_LO),
        .N_DEV  (N_DEV),
        .IDX_W  (IDX_W)
    ) u_decode (
        .i_field  (cpu_addr[SEL_HI:SEL_LO]),
        .o_hit    (w_hit),
        .o_index  (w_idx),
        .o_onehot (w_onehot)
    );

    // Only the selected device's ack and read bus are ever looked at.
    assign w_dev_ack   = dev_ack[r_idx];
    assign w_dev_rdata = dev_rdata[r_idx*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_dev_sel   <= '0;
            r_dev_we    <= 1'b0;
            r_dev_addr  <= '0;
            r_dev_wdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_cpu_rdata <= '0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_req) begin
                        r_dev_we    <= cpu_we;
                        r_dev_addr  <= cpu_addr;
                        r_dev_wdata <= cpu_wdata;
                        r_idx       <= w_idx;
                        r_cnt       <= '0;
                        if (w_hit) begin
                            r_dev_sel <= w_onehot;
                            r_state   <= ACCESS;
                        end else begin
                            r_cpu_ack   <= 1'b1;
                            r_cpu_err   <= 1'b1;
                            r_cpu_rdata <= DATA_W'(ERR_RDATA);
                            r_state     <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    // An ack in the final allowed cycle still beats the timeout.
                    if (w_dev_ack) begin
                        r_dev_sel <= '0;
                        r_cpu_ack <= 1'b1;
                        r_cpu_err <= 1'b0;
                        if (!r_dev_we) begin
                            r_cpu_rdata <= w_dev_rdata;
                        end
                        r_state <= RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_dev_sel   <= '0;
                        r_cpu_ack   <= 1'b1;
                        r_cpu_err   <= 1'b1;
                        r_cpu_rdata <= DATA_W'(ERR_RDATA);
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    r_cpu_ack <= 1'b0;
                    r_cpu_err <= 1'b0;
                    if (r_cpu_err && r_err_count != 8'hFF) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cpu_ack   = r_cpu_ack;
    assign cpu_err   = r_cpu_err;
    assign cpu_rdata = r_cpu_rdata;
    assign dev_sel   = r_dev_sel;
    assign dev_we    = r_dev_we;
    assign dev_addr  = r_dev_addr;
    assign dev_wdata = r_dev_wdata;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Self-checking bench for io_bus_ctrl: hand-computed vector table, a reset-abort sequence,
// randomized accesses checked against a transaction-level model, and error-count saturation.
module tb_io_bus_ctrl;

    localparam int N_DEV   = 8;
    localparam int TIMEOUT = 15;

    logic             clk;
    logic             rst;
    logic             cpu_req;
    logic             cpu_we;
    logic [31:0]      cpu_addr;
    logic [31:0]      cpu_wdata;
    logic             cpu_ack;
    logic             cpu_err;
    logic [31:0]      cpu_rdata;
    logic [N_DEV-1:0] dev_sel;
    logic             dev_we;
    logic [31:0]      dev_addr;
    logic [31:0]      dev_wdata;
    logic [N_DEV*32-1:0] dev_rdata;
    logic [N_DEV-1:0] dev_ack;
    logic [7:0]       err_count;

    int checks;
    int failures;

    logic [31:0] modelRdata;
    logic [7:0]  modelErrCnt;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ackAt;
        logic [31:0] devData;
        int          noiseIdx;
        bit          holdReq;
        logic [7:0]  expSel;
        int          expLat;
        logic        expErr;
        logic [31:0] expRdata;
        logic [7:0]  expErrCount;
    } vec_t;

    vec_t tbl[9];

    io_bus_ctrl #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .SEL_HI  (31),
        .SEL_LO  (20),
        .N_DEV   (N_DEV),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .cpu_rdata (cpu_rdata),
        .dev_sel   (dev_sel),
        .dev_we    (dev_we),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_rdata (dev_rdata),
        .dev_ack   (dev_ack),
        .err_count (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".cpu_ack"}, 32'(cpu_ack), 32'd0);
        checkOutput({tag, ".cpu_err"}, 32'(cpu_err), 32'd0);
        checkOutput({tag, ".cpu_rdata"}, cpu_rdata, 32'd0);
        checkOutput({tag, ".dev_sel"}, 32'(dev_sel), 32'd0);
        checkOutput({tag, ".dev_we"}, 32'(dev_we), 32'd0);
        checkOutput({tag, ".dev_addr"}, dev_addr, 32'd0);
        checkOutput({tag, ".dev_wdata"}, dev_wdata, 32'd0);
        checkOutput({tag, ".err_count"}, 32'(err_count), 32'd0);
    endtask

    function automatic vec_t mkVec(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                   input int ackAt, input logic [31:0] devData, input int noiseIdx,
                                   input bit holdReq, input logic [7:0] expSel, input int expLat,
                                   input logic expErr, input logic [31:0] expRdata, input logic [7:0] expErrCount);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.ackAt = ackAt; v.devData = devData;
        v.noiseIdx = noiseIdx; v.holdReq = holdReq; v.expSel = expSel; v.expLat = expLat;
        v.expErr = expErr; v.expRdata = expRdata; v.expErrCount = expErrCount;
        return v;
    endfunction

    // Transaction-level reference: outcome follows from region mapping and device latency alone.
    function automatic vec_t modelVec(input logic we, input int f, input int ackAt,
                                      input logic [31:0] devData, input int noiseIdx);
        vec_t v;
        logic [31:0] fv;
        fv = 32'(f);
        v.we = we;
        v.addr = {fv[11:0], 20'($urandom)};
        v.wdata = $urandom;
        v.ackAt = ackAt;
        v.devData = devData;
        v.noiseIdx = noiseIdx;
        v.holdReq = 1'b0;
        if (f < 1 || f > N_DEV) begin
            v.expSel = 8'h00; v.expLat = 1; v.expErr = 1'b1; v.expRdata = 32'd0;
        end else if (ackAt >= 1 && ackAt <= TIMEOUT) begin
            v.expSel = 8'(1 << (f - 1)); v.expLat = ackAt + 1; v.expErr = 1'b0;
            v.expRdata = we ? modelRdata : devData;
        end else begin
            v.expSel = 8'(1 << (f - 1)); v.expLat = TIMEOUT + 1; v.expErr = 1'b1; v.expRdata = 32'd0;
        end
        if (v.expErr) v.expErrCount = (modelErrCnt == 8'hFF) ? 8'hFF : modelErrCnt + 8'd1;
        else          v.expErrCount = modelErrCnt;
        return v;
    endfunction

    // Runs one access starting from an IDLE negedge and ends on the following IDLE negedge.
    task automatic applyStimulus(input vec_t v);
        int f;
        int idx;
        f = int'(v.addr[31:20]);
        idx = (f >= 1 && f <= N_DEV) ? f - 1 : -1;
        for (int d = 0; d < N_DEV; d++) dev_rdata[d*32 +: 32] = $urandom;
        if (idx >= 0) dev_rdata[idx*32 +: 32] = v.devData;
        cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        for (int c = 1; c <= v.expLat; c++) begin
            @(negedge clk);
            if (!v.holdReq || c == v.expLat) cpu_req = 1'b0;
            cpu_we = ~v.we; cpu_addr = $urandom; cpu_wdata = $urandom;
            dev_ack = '0;
            checkOutput("dev_sel", 32'(dev_sel), (c < v.expLat) ? 32'(v.expSel) : 32'd0);
            checkOutput("cpu_ack", 32'(cpu_ack), (c == v.expLat) ? 32'd1 : 32'd0);
            if (c < v.expLat && v.expSel != 8'h00) begin
                checkOutput("dev_we", 32'(dev_we), 32'(v.we));
                checkOutput("dev_addr", dev_addr, v.addr);
                checkOutput("dev_wdata", dev_wdata, v.wdata);
            end
            if (c == v.expLat) begin
                checkOutput("cpu_err", 32'(cpu_err), 32'(v.expErr));
                checkOutput("cpu_rdata", cpu_rdata, v.expRdata);
            end else begin
                if (idx >= 0 && c == v.ackAt) dev_ack[idx] = 1'b1;
                if (c == 1 && v.noiseIdx >= 0) dev_ack[v.noiseIdx] = 1'b1;
            end
        end
        @(negedge clk);
        dev_ack = '0; cpu_req = 1'b0;
        checkOutput("idle.cpu_ack", 32'(cpu_ack), 32'd0);
        checkOutput("idle.dev_sel", 32'(dev_sel), 32'd0);
        checkOutput("err_count", 32'(err_count), 32'(v.expErrCount));
        checkOutput("rdata_hold", cpu_rdata, v.expRdata);
    endtask

    initial begin
        vec_t v;
        int f;
        int noise;
        checks = 0; failures = 0;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dev_rdata = '0; dev_ack = '0;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);

        // we, addr, wdata, ackAt, devData, noise, hold | sel, lat, err, rdata, errCount
        tbl[0] = mkVec(0, 32'h0010_0040, 32'h0,  1, 32'h1234_5678, -1, 0, 8'h01,  2, 0, 32'h1234_5678, 8'd0);
        tbl[1] = mkVec(1, 32'h0020_0004, 32'hAB, 3, 32'hDEAD_0000, -1, 0, 8'h02,  4, 0, 32'h1234_5678, 8'd0);
        tbl[2] = mkVec(0, 32'h0000_0000, 32'h0,  1, 32'h0,         -1, 0, 8'h00,  1, 1, 32'h0,         8'd1);
        tbl[3] = mkVec(1, 32'h0090_0000, 32'h5,  1, 32'h0,         -1, 0, 8'h00,  1, 1, 32'h0,         8'd2);
        tbl[4] = mkVec(0, 32'h0070_0000, 32'h0,  0, 32'h1111_1111, -1, 0, 8'h40, 16, 1, 32'h0,         8'd3);
        tbl[5] = mkVec(0, 32'h0070_0010, 32'h0, 15, 32'hCAFE_F00D, -1, 0, 8'h40, 16, 0, 32'hCAFE_F00D, 8'd3);
        tbl[6] = mkVec(0, 32'h0010_0000, 32'h0,  2, 32'h5555_AAAA,  2, 1, 8'h01,  3, 0, 32'h5555_AAAA, 8'd3);
        tbl[7] = mkVec(0, 32'h0080_00FC, 32'h0,  1, 32'h0BAD_BEEF, -1, 0, 8'h80,  2, 0, 32'h0BAD_BEEF, 8'd3);
        tbl[8] = mkVec(1, 32'h0040_0000, 32'h77, 0, 32'h0,         -1, 0, 8'h08, 16, 1, 32'h0,         8'd4);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i]);
            if (tbl[i].holdReq) begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    checkOutput("extra_ack", 32'(cpu_ack), 32'd0);
                end
            end
        end

        // Reset in the third ACCESS cycle aborts the access without an ack.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0010_0000;
        @(negedge clk); cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_reset.dev_sel", 32'(dev_sel), 32'h01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkAllZero("midreset");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("post_reset.cpu_ack", 32'(cpu_ack), 32'd0);
        end
        modelRdata = 32'd0; modelErrCnt = 8'd0;
        v = modelVec(0, 1, 1, 32'h600D_0001, -1);
        applyStimulus(v);
        modelRdata = v.expRdata; modelErrCnt = v.expErrCount;

        for (int n = 0; n < 40; n++) begin
            f = $urandom_range(0, 10);
            noise = $urandom_range(0, N_DEV - 1);
            if (noise == f - 1) noise = -1;
            v = modelVec(1'($urandom), f, $urandom_range(0, TIMEOUT + 2), $urandom, noise);
            applyStimulus(v);
            modelRdata = v.expRdata; modelErrCnt = v.expErrCount;
        end

        for (int n = 0; n < 260; n++) begin
            v = modelVec(1'($urandom), (n % 2 == 0) ? 0 : 12, 1, 32'h0, -1);
            applyStimulus(v);
            modelRdata = v.expRdata; modelErrCnt = v.expErrCount;
        end
        checkOutput("err_count_sat", 32'(err_count), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_bus_ctrl.md
# io_bus_ctrl

Parametrised memory-mapped I/O bus controller; successor to the single-cycle combinational address decoder. It sits between the CPU load/store port and N peripheral slaves (dmem, VGA text/offset/colour/cursor, keyboard, timer, …). It decodes a configurable address field, runs a request/acknowledge handshake with variable-latency devices and returns read data. Unmapped or unresponsive accesses complete with an error flag instead of hanging the CPU.

## Interface
Parameters:
- DATA_W, 32, data width
- ADDR_W, 32, address width
- SEL_HI, 31, MSB of region-select field
- SEL_LO, 20, LSB of region-select field
- N_DEV, 8, number of device slots (1..15)
- TIMEOUT, 15, max ACCESS cycles before error (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  access request, sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  DATA_W  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  valid with cpu_ack: unmapped or timed out
- cpu_rdata  out  DATA_W  read data, valid from cpu_ack until next cpu_ack
- dev_sel  out  N_DEV  one-hot device select
- dev_we  out  1  latched write enable, qualified by dev_sel
- dev_addr  out  ADDR_W  latched address
- dev_wdata  out  DATA_W  latched write data
- dev_rdata  in  N_DEV*DATA_W  flat read buses, device i at [i*DATA_W +: DATA_W]
- dev_ack  in  N_DEV  per-device done
- err_count  out  8  saturating count of error completions

## Operation
- Region field f = cpu_addr[SEL_HI:SEL_LO]. Device index i = f−1 when 1 ≤ f ≤ N_DEV; otherwise unmapped. Defaults give f=1 dmem, 2 VGA, 3 key, …, 7 timer.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: on cpu_req, latch we/addr/wdata and decode. Mapped → ACCESS with dev_sel[i]=1 and wait counter cleared. Unmapped → RESP with err=1, rdata=0; no dev_sel asserted.
- ACCESS: dev_sel, dev_we, dev_addr and dev_wdata are held constant. If dev_ack[i]=1 → capture dev_rdata slice i (reads only; writes leave cpu_rdata unchanged), err=0, go to RESP. Else increment counter; when counter = TIMEOUT−1 without ack → RESP with err=1, rdata=0.
- dev_ack from non-selected devices is ignored in all states. dev_ack in IDLE or RESP is ignored.
- RESP: cpu_ack=1 for exactly one cycle, cpu_err per capture; dev_sel=0; return to IDLE. On err, err_count increments, saturating at 255.
- cpu_req in ACCESS/RESP is ignored (not queued). The CPU must re-request after cpu_ack.
- Back-to-back: cpu_req may be re-sampled in the IDLE cycle immediately following RESP.

## Timing
- Reset (rst=1 at edge): state IDLE; cpu_ack, cpu_err, dev_sel, dev_we = 0; cpu_rdata, dev_addr, dev_wdata = 0; counter = 0; err_count = 0. Reset mid-ACCESS aborts the access with no cpu_ack.
- Mapped, device acks in first ACCESS cycle: req sampled at edge 0, dev_sel high in cycle 1, cpu_ack in cycle 2 (latency 2).
- Device acking after k ACCESS cycles (k ≥ 1): cpu_ack at cycle k+1.
- Timeout: dev_sel high for exactly TIMEOUT cycles, cpu_ack+cpu_err in the next cycle.
- Unmapped: cpu_ack+cpu_err in cycle 1 (latency 1).
- Minimum request spacing 3 cycles (mapped), 2 cycles (unmapped).
- Ack arriving in the same cycle the counter expires: ack wins, no error.

## Structure
- Package io_bus_pkg: state enum (IDLE/ACCESS/RESP), ERR_RDATA = 0 constant, counter width function clog2(TIMEOUT+1).
- Sub-module io_bus_decode (combinational): region field → {hit, index, one-hot}, parametrised by SEL_HI/SEL_LO/N_DEV. All state lives in io_bus_ctrl.

## Test plan
- Read dev 0: addr 0x0010_0040, dev_ack[0] in first ACCESS cycle, dev_rdata[0]=0x1234_5678 → cpu_ack at cycle 2, cpu_rdata=0x1234_5678, cpu_err=0, dev_sel=0x01 during cycle 1 only.
- Write dev 1 with 3-cycle device: addr 0x0020_0004, wdata 0xAB, ack on 3rd ACCESS cycle → dev_we=1 and dev_wdata=0xAB held for 3 cycles, cpu_ack at cycle 4, cpu_rdata unchanged.
- Unmapped: addr 0x0000_0000 and 0x0090_0000 (N_DEV=8) → cpu_ack+cpu_err at cycle 1, dev_sel never asserted, err_count 0→1→2.
- Timeout (TIMEOUT=15): dev 6 never acks → dev_sel=0x40 for 15 cycles, ack+err at cycle 16, cpu_rdata=0. Variant: ack on 15th cycle → no error.
- Noise: dev_ack[2] pulsed while dev 0 selected, and cpu_req held high through ACCESS → ignored; exactly one completion per sampled request.
- Reset mid-ACCESS at cycle 3 → no cpu_ack, all outputs 0, and a new request after reset completes normally.
